// File: rtl/seq_divider.sv
// seq_divider -- sequential restoring divider for unsigned operands.
//
// Divides dividend by divisor one quotient bit per clock, MSB first, using a
// WIDTH+1 bit partial remainder so the trial subtraction never overflows.
// A request is taken while in_ready is high; the result appears one cycle
// later than the WIDTH-th step, marked by a single-cycle out_valid pulse, and
// then stays on quotient/remainder/div_by_zero until the next request is
// accepted. Dividing by zero falls out of the algorithm naturally: quotient
// is all ones, remainder equals the dividend, and div_by_zero is raised.
//
// Ports:
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     request strobe, only looked at while in_ready is high
//   dividend     unsigned numerator, sampled with in_valid
//   divisor      unsigned denominator, sampled with in_valid
//   in_ready     high while the divider is idle
//   quotient     result quotient
//   remainder    result remainder
//   div_by_zero  high with the result when the accepted divisor was zero
//   out_valid    one-cycle pulse marking the result valid
//
// Build option:
//   DIV_EARLY_EXIT_EN  when defined, a zero divisor or a dividend smaller
//                      than the divisor finishes straight from acceptance.
//                      When undefined, every division takes exactly WIDTH
//                      steps regardless of operand values (constant time).

`timescale 1ns/1ps

module seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             in_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             out_valid
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_dvd;
   logic [WIDTH-1:0] r_divisor;
   logic [WIDTH:0]   r_rem;
   logic [WIDTH-1:0] r_quot;
   logic             r_dbz;

   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_diff;
   logic             w_fits;
   logic             w_lastStep;
   logic             w_early;

   // One restoring step: bring the next dividend bit into the partial
   // remainder and try to take the divisor out of it. Both sides of the
   // compare are WIDTH+1 bits so a shifted remainder above 2^WIDTH-1 is
   // still handled correctly.
   always_comb begin
      w_shift    = (r_rem << 1) | {{WIDTH{1'b0}}, r_dvd[WIDTH-1]};
      w_fits     = (w_shift >= {1'b0, r_divisor});
      w_diff     = w_shift - {1'b0, r_divisor};
      w_lastStep = (r_count == CW'(WIDTH - 1));
   end

   // Early termination only exists when the build option is on; otherwise
   // the divider must never take an operand-dependent path.
   always_comb begin
`ifdef DIV_EARLY_EXIT_EN
      w_early = (divisor == '0) || (dividend < divisor);
`else
      w_early = 1'b0;
`endif
   end

   // State register for the IDLE -> BUSY -> DONE -> IDLE cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and handshake outputs. Requests arriving while BUSY or DONE
   // are simply not looked at, so nothing is queued.
   always_comb begin
      w_nextState = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_nextState = w_early ? DONE : BUSY;
            end
         end
         BUSY: begin
            if (w_lastStep) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            out_valid   = 1'b1;
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Datapath. Acceptance latches the operands and clears the previous
   // result; each BUSY cycle performs one step; the result registers are
   // left alone in DONE and IDLE so the answer stays visible until the next
   // request replaces it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count   <= '0;
         r_dvd     <= '0;
         r_divisor <= '0;
         r_rem     <= '0;
         r_quot    <= '0;
         r_dbz     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_dvd     <= dividend;
                  r_divisor <= divisor;
                  r_count   <= '0;
                  if (w_early) begin
                     r_quot <= {WIDTH{divisor == '0}};
                     r_rem  <= {1'b0, dividend};
                     r_dbz  <= (divisor == '0);
                  end else begin
                     r_quot <= '0;
                     r_rem  <= '0;
                     r_dbz  <= 1'b0;
                  end
               end
            end
            BUSY: begin
               r_dvd   <= {r_dvd[WIDTH-2:0], 1'b0};
               r_rem   <= w_fits ? w_diff : w_shift;
               r_quot  <= {r_quot[WIDTH-2:0], w_fits};
               r_count <= r_count + CW'(1);
               if (w_lastStep) begin
                  r_dbz <= (r_divisor == '0);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // The quotient/remainder registers double as the held result.
   always_comb begin
      quotient    = r_quot;
      remainder   = r_rem[WIDTH-1:0];
      div_by_zero = r_dbz;
   end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand width in bits (WIDTH >= 2).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: in_valid  input  1  request strobe; sampled only when in_ready=1.
REQ-005 SHALL have port: dividend  input  WIDTH  unsigned numerator, sampled with in_valid.
REQ-006 SHALL have port: divisor  input  WIDTH  unsigned denominator, sampled with in_valid.
REQ-007 SHALL have port: in_ready  output  1  high exactly when state=IDLE.
REQ-008 SHALL have port: quotient  output  WIDTH  registered result.
REQ-009 SHALL have port: remainder  output  WIDTH  registered result.
REQ-010 SHALL have port: div_by_zero  output  1  high with result when accepted divisor was 0.
REQ-011 SHALL have port: out_valid  output  1  one-cycle pulse marking result valid.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE; encoding free.
REQ-013 Accept: in IDLE with in_valid=1 at edge E0 -> latch dividend/divisor, clear partial remainder and quotient, counter=0, state=BUSY.
REQ-014 in_valid in BUSY or DONE SHALL be ignored; no queuing, latched operands unchanged.
REQ-015 BUSY: one restoring step per edge -- shift {partial remainder, dividend MSB} left 1; if shifted value >= divisor, subtract divisor and shift 1 into quotient, else shift 0.
REQ-016 Partial remainder datapath SHALL be WIDTH+1 bits; no overflow for any operand pair.
REQ-017 Counter SHALL be clog2(WIDTH)+1 bits; after the WIDTH-th step (edge E_WIDTH) state=DONE.
REQ-018 DONE lasts exactly one cycle: out_valid=1, quotient/remainder/div_by_zero final; next edge -> IDLE, out_valid=0.
REQ-019 Latency: out_valid high in the cycle after edge E_WIDTH, i.e. WIDTH edges after acceptance (macro off).
REQ-020 quotient, remainder, div_by_zero SHALL hold their values from DONE until the next acceptance clears them.
REQ-021 Divisor 0 (natural algorithm result): quotient = all ones, remainder = dividend, div_by_zero=1.
REQ-022 Minimum accept-to-accept interval: WIDTH+2 edges; in_ready rises the cycle after DONE.
REQ-023 Results SHALL satisfy dividend = quotient*divisor + remainder, remainder < divisor, for divisor != 0.

Reset
REQ-024 rst_n low SHALL immediately (asynchronously) force state=IDLE, counter=0, quotient=0, remainder=0, div_by_zero=0, out_valid=0, in_ready=1, latched operands=0.
REQ-025 Reset mid-BUSY or mid-DONE SHALL abort the operation with no out_valid pulse; first edge after rst_n deasserts may accept.

Configuration
REQ-026 Macro DIV_EARLY_EXIT_EN SHALL control data-dependent early termination.
REQ-027 Defined: at accept, if divisor==0 or dividend<divisor, go directly IDLE->DONE at E0; out_valid 1 edge after acceptance; results per REQ-021 or quotient=0, remainder=dividend.
REQ-028 Defined: all other operands use full WIDTH-step latency.
REQ-029 Undefined: latency SHALL be exactly WIDTH edges for every operand pair (constant-time, no operand-dependent timing); results identical to defined case.

Verification (WIDTH=8)
REQ-030 dividend=100, divisor=7 accepted at E0 -> out_valid only in cycle after E8, quotient=14, remainder=2, div_by_zero=0.
REQ-031 dividend=5, divisor=9 -> quotient=0, remainder=5; out_valid after E8 (macro off) or after E0 (macro on).
REQ-032 dividend=200, divisor=0 -> quotient=255, remainder=200, div_by_zero=1; latency 8 (off) / 1 (on).
REQ-033 accept 255/16, pulse in_valid with 3/1 at E3 and in DONE -> result quotient=15, remainder=15, second request dropped, in_ready=0 throughout.
REQ-034 accept 100/7, drop rst_n between E4 and E5 -> all outputs 0 immediately, no out_valid; after release 9/3 -> quotient=3, remainder=0 after 8 edges.
REQ-035 two differing-operand runs (200/3 vs 2/200) with macro off -> out_valid at identical edge offsets; exhaustive 256x256 run matches reference model.
